// File: rtl/board_writer.sv
// rtl/board_writer.sv - Gomoku board store write side: placement validation,
// stone write, checker handshake and game-state/turn update.
module board_writer #(
  parameter int SIZE  = 15,
  parameter int CELLS = SIZE * SIZE,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          place,
  input  logic [AW-1:0] pointer,
  input  logic [AW-1:0] chk_addr,
  output logic [1:0]    chk_data,
  output logic          chk_active,
  input  logic          chk_success,
  input  logic          chk_fail,
  output logic [AW-1:0] last_move,
  output logic          player,
  output logic [1:0]    state,
  output logic          busy,
  output logic          reject
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd1;
  localparam logic [1:0] ST_OVER  = 2'd2;

  localparam logic [AW-1:0] CELLS_IDX = AW'(CELLS);
  localparam logic [7:0]    CELLS_CNT = 8'(CELLS);

  logic [1:0] cells [CELLS];
  logic [1:0] fsm;
  logic [7:0] move_count;
  logic [1:0] cell_at_ptr;
  logic       ptr_free;
  logic [1:0] stone;

  // Out-of-range indices read as empty on both ports so the array is never
  // indexed past its end.
  always_comb begin
    cell_at_ptr = 2'd0;
    chk_data    = 2'd0;
    if (pointer < CELLS_IDX) cell_at_ptr = cells[pointer];
    if (chk_addr < CELLS_IDX) chk_data = cells[chk_addr];
  end

  assign ptr_free   = (pointer < CELLS_IDX) && (cell_at_ptr == 2'd0);
  assign stone      = {player, ~player};
  assign chk_active = (fsm == ST_CHECK);
  assign busy       = (fsm != ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CELLS; i++) cells[i] <= 2'd0;
      fsm        <= ST_IDLE;
      move_count <= 8'd0;
      last_move  <= '0;
      player     <= 1'b0;
      state      <= 2'd0;
      reject     <= 1'b0;
    end else begin
      reject <= 1'b0;
      case (fsm)
        ST_IDLE: begin
          if (place) begin
            if (!ptr_free) begin
              reject <= 1'b1;
            end else begin
              cells[pointer] <= stone;
              last_move      <= pointer;
              if (move_count != CELLS_CNT) move_count <= move_count + 8'd1;
              fsm <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          // A simultaneous success and fail is treated as a win.
          if (chk_success) begin
            state <= stone;
            fsm   <= ST_OVER;
          end else if (chk_fail) begin
            if (move_count == CELLS_CNT) begin
              state <= 2'd3;
              fsm   <= ST_OVER;
            end else begin
              player <= ~player;
              fsm    <= ST_IDLE;
            end
          end
        end
        ST_OVER: fsm <= ST_OVER;
        default: fsm <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_board_writer.sv
// tb/tb_board_writer.sv - self-checking bench for board_writer against a
// board-level reference model.
module tb_board_writer;

  localparam int CELLS = 225;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       place = 1'b0;
  logic [7:0] pointer = 8'd0;
  logic [7:0] chk_addr = 8'd0;
  logic       chk_success = 1'b0;
  logic       chk_fail = 1'b0;
  logic [1:0] chk_data;
  logic       chk_active;
  logic [7:0] last_move;
  logic       player;
  logic [1:0] state;
  logic       busy;
  logic       reject;

  board_writer dut (
    .clk(clk), .reset(reset), .place(place), .pointer(pointer),
    .chk_addr(chk_addr), .chk_data(chk_data), .chk_active(chk_active),
    .chk_success(chk_success), .chk_fail(chk_fail), .last_move(last_move),
    .player(player), .state(state), .busy(busy), .reject(reject)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  int ref_cell [CELLS];
  int ref_player, ref_state, ref_count, ref_last;

  task automatic model_reset();
    foreach (ref_cell[i]) ref_cell[i] = 0;
    ref_player = 0; ref_state = 0; ref_count = 0; ref_last = 0;
  endtask

  function automatic bit model_ok(int p);
    return (p < CELLS) && (ref_cell[p] == 0);
  endfunction

  function automatic int model_read(int a);
    return (a < CELLS) ? ref_cell[a] : 0;
  endfunction

  task automatic model_accept(int p);
    ref_cell[p] = ref_player + 1;
    ref_last = p;
    if (ref_count < CELLS) ref_count++;
  endtask

  task automatic model_verdict(bit s, bit f);
    if (s) ref_state = ref_player + 1;
    else if (f) begin
      if (ref_count == CELLS) ref_state = 3;
      else ref_player = 1 - ref_player;
    end
  endtask

  // Stimulus helpers: start and finish just after a falling edge.
  task automatic do_reset();
    @(negedge clk) reset = 1'b1;
    @(negedge clk) reset = 1'b0;
    model_reset();
  endtask

  task automatic do_place(int p);
    place = 1'b1;
    pointer = 8'(p);
    @(negedge clk);
    place = 1'b0;
  endtask

  task automatic give_verdict(bit s, bit f);
    chk_success = s;
    chk_fail = f;
    @(negedge clk);
    chk_success = 1'b0;
    chk_fail = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp++; if (chk_active !== 1'b0) begin n_err++; $display("FAIL reset_chk_active got %b want 0", chk_active); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (reject !== 1'b0) begin n_err++; $display("FAIL reset_reject got %b want 0", reject); end
    n_cmp++; if (player !== 1'b0) begin n_err++; $display("FAIL reset_player got %b want 0", player); end
    n_cmp++; if (state !== 2'd0) begin n_err++; $display("FAIL reset_state got %0d want 0", state); end
    n_cmp++; if (last_move !== 8'd0) begin n_err++; $display("FAIL reset_last_move got %0d want 0", last_move); end
    for (int i = 0; i < 4; i++) begin
      chk_addr = 8'($urandom_range(0, CELLS - 1)); #1;
      n_cmp++; if (chk_data !== 2'd0) begin n_err++; $display("FAIL reset_cell[%0d] got %0d want 0", chk_addr, chk_data); end
    end
  endtask

  task automatic test_first_move();
    do_reset();
    do_place(112);
    n_cmp++; if (chk_active !== 1'b1) begin n_err++; $display("FAIL first_chk_active got %b want 1", chk_active); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL first_busy got %b want 1", busy); end
    n_cmp++; if (reject !== 1'b0) begin n_err++; $display("FAIL first_reject got %b want 0", reject); end
    n_cmp++; if (last_move !== 8'd112) begin n_err++; $display("FAIL first_last_move got %0d want 112", last_move); end
    chk_addr = 8'd112; #1;
    n_cmp++; if (chk_data !== 2'd1) begin n_err++; $display("FAIL first_cell112 got %0d want 1", chk_data); end
    give_verdict(1'b0, 1'b1);
    n_cmp++; if (player !== 1'b1) begin n_err++; $display("FAIL first_player got %b want 1", player); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL first_busy_after got %b want 0", busy); end
    n_cmp++; if (chk_active !== 1'b0) begin n_err++; $display("FAIL first_chk_active_after got %b want 0", chk_active); end
  endtask

  task automatic test_double_place();
    do_place(112);
    n_cmp++; if (reject !== 1'b1) begin n_err++; $display("FAIL dup_reject got %b want 1", reject); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL dup_busy got %b want 0", busy); end
    n_cmp++; if (player !== 1'b1) begin n_err++; $display("FAIL dup_player got %b want 1", player); end
    @(negedge clk);
    n_cmp++; if (reject !== 1'b0) begin n_err++; $display("FAIL dup_reject_width got %b want 0", reject); end
    chk_addr = 8'd112; #1;
    n_cmp++; if (chk_data !== 2'd1) begin n_err++; $display("FAIL dup_cell112 got %0d want 1", chk_data); end
  endtask

  task automatic test_out_of_range();
    do_place(225);
    n_cmp++; if (reject !== 1'b1) begin n_err++; $display("FAIL oor_reject got %b want 1", reject); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL oor_busy got %b want 0", busy); end
    chk_addr = 8'd225; #1;
    n_cmp++; if (chk_data !== 2'd0) begin n_err++; $display("FAIL oor_read225 got %0d want 0", chk_data); end
    chk_addr = 8'd255; #1;
    n_cmp++; if (chk_data !== 2'd0) begin n_err++; $display("FAIL oor_read255 got %0d want 0", chk_data); end
  endtask

  task automatic test_success_win();
    do_reset();
    do_place(10);
    give_verdict(1'b0, 1'b1);
    do_place(20);
    chk_addr = 8'd20; #1;
    n_cmp++; if (chk_data !== 2'd2) begin n_err++; $display("FAIL win_cell20 got %0d want 2", chk_data); end
    give_verdict(1'b1, 1'b0);
    n_cmp++; if (state !== 2'd2) begin n_err++; $display("FAIL win_state got %0d want 2", state); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL win_busy got %b want 1", busy); end
    n_cmp++; if (chk_active !== 1'b0) begin n_err++; $display("FAIL win_chk_active got %b want 0", chk_active); end
    do_place(30);
    n_cmp++; if (reject !== 1'b0) begin n_err++; $display("FAIL over_reject got %b want 0", reject); end
    chk_addr = 8'd30; #1;
    n_cmp++; if (chk_data !== 2'd0) begin n_err++; $display("FAIL over_cell30 got %0d want 0", chk_data); end
    n_cmp++; if (last_move !== 8'd20) begin n_err++; $display("FAIL over_last_move got %0d want 20", last_move); end
  endtask

  task automatic test_both_verdicts();
    do_reset();
    do_place(0);
    give_verdict(1'b1, 1'b1);
    n_cmp++; if (state !== 2'd1) begin n_err++; $display("FAIL both_state got %0d want 1", state); end
    n_cmp++; if (player !== 1'b0) begin n_err++; $display("FAIL both_player got %b want 0", player); end
  endtask

  task automatic test_random();
    int p, a, d, r;
    bit ok, s, f;
    do_reset();
    for (int it = 0; it < 120 && ref_state == 0; it++) begin
      p = $urandom_range(0, 239);
      ok = model_ok(p);
      do_place(p);
      n_cmp++; if (reject !== !ok) begin n_err++; $display("FAIL rnd_reject p=%0d got %b want %b", p, reject, !ok); end
      n_cmp++; if (busy !== ok) begin n_err++; $display("FAIL rnd_busy p=%0d got %b want %b", p, busy, ok); end
      if (ok) begin
        model_accept(p);
        n_cmp++; if (last_move !== 8'(ref_last)) begin n_err++; $display("FAIL rnd_last_move got %0d want %0d", last_move, ref_last); end
        d = $urandom_range(0, 3);
        for (int k = 0; k < d; k++) begin
          place = 1'b1; pointer = 8'($urandom);
          @(negedge clk);
          place = 1'b0;
          n_cmp++; if (reject !== 1'b0 || chk_active !== 1'b1) begin n_err++; $display("FAIL rnd_check_hold reject=%b chk_active=%b want 0/1", reject, chk_active); end
        end
        r = $urandom_range(0, 29);
        s = (r <= 1);
        f = (r != 0);
        give_verdict(s, f);
        model_verdict(s, f);
        n_cmp++; if (state !== 2'(ref_state)) begin n_err++; $display("FAIL rnd_state got %0d want %0d", state, ref_state); end
        n_cmp++; if (player !== 1'(ref_player)) begin n_err++; $display("FAIL rnd_player got %b want %0d", player, ref_player); end
        n_cmp++; if (busy !== (ref_state != 0)) begin n_err++; $display("FAIL rnd_busy_after got %b want %b", busy, ref_state != 0); end
      end
      a = $urandom_range(0, 255);
      chk_addr = 8'(a); #1;
      n_cmp++; if (chk_data !== 2'(model_read(a))) begin n_err++; $display("FAIL rnd_read a=%0d got %0d want %0d", a, chk_data, model_read(a)); end
    end
    if (ref_state != 0) begin
      do_place($urandom_range(0, CELLS - 1));
      n_cmp++; if (reject !== 1'b0) begin n_err++; $display("FAIL rnd_over_reject got %b want 0", reject); end
    end
    for (int i = 0; i < CELLS; i++) begin
      chk_addr = 8'(i); #1;
      if (chk_data !== 2'(ref_cell[i])) begin
        n_cmp++; n_err++; $display("FAIL rnd_board cell=%0d got %0d want %0d", i, chk_data, ref_cell[i]);
      end
    end
    n_cmp++;
  endtask

  task automatic test_fill_draw();
    do_reset();
    for (int p = 0; p < CELLS; p++) begin
      do_place(p);
      model_accept(p);
      n_cmp++; if (busy !== 1'b1 || reject !== 1'b0) begin n_err++; $display("FAIL fill_accept p=%0d busy=%b reject=%b want 1/0", p, busy, reject); end
      give_verdict(1'b0, 1'b1);
      model_verdict(1'b0, 1'b1);
      n_cmp++; if (state !== 2'(ref_state)) begin n_err++; $display("FAIL fill_state p=%0d got %0d want %0d", p, state, ref_state); end
    end
    n_cmp++; if (state !== 2'd3) begin n_err++; $display("FAIL draw_state got %0d want 3", state); end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL draw_busy got %b want 1", busy); end
    n_cmp++; if (last_move !== 8'd224) begin n_err++; $display("FAIL draw_last_move got %0d want 224", last_move); end
    for (int i = 0; i < CELLS; i++) begin
      chk_addr = 8'(i); #1;
      if (chk_data !== 2'(ref_cell[i])) begin
        n_cmp++; n_err++; $display("FAIL draw_board cell=%0d got %0d want %0d", i, chk_data, ref_cell[i]);
      end
    end
    n_cmp++;
  endtask

  task automatic test_reset_in_check();
    do_reset();
    do_place(40);
    give_verdict(1'b0, 1'b1);
    do_place(50);
    #2 reset = 1'b1;
    #1;
    chk_addr = 8'd50;
    #1;
    n_cmp++; if (chk_active !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL arst_active_busy got %b/%b want 0/0", chk_active, busy); end
    n_cmp++; if (player !== 1'b0 || state !== 2'd0) begin n_err++; $display("FAIL arst_player_state got %b/%0d want 0/0", player, state); end
    n_cmp++; if (last_move !== 8'd0) begin n_err++; $display("FAIL arst_last_move got %0d want 0", last_move); end
    n_cmp++; if (chk_data !== 2'd0) begin n_err++; $display("FAIL arst_cell50 got %0d want 0", chk_data); end
    @(negedge clk) reset = 1'b0;
    model_reset();
    test_reset();
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_first_move();
    test_double_place();
    test_out_of_range();
    test_success_win();
    test_both_verdicts();
    test_random();
    test_fill_draw();
    test_reset_in_check();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
